// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_stream_arbiter
// N:1 ready/valid round-robin arbiter with bounded burst lock and a single
// registered output stage (full throughput, 1-cycle latency).
// Rev    : 1.0
// ============================================================================
module rr_stream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 28,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            up_valid,
  input  logic [N_REQ*DATA_W-1:0]     up_data,
  output logic [N_REQ-1:0]            up_ready,
  output logic                        down_valid,
  output logic [DATA_W-1:0]           down_data,
  output logic [$clog2(N_REQ)-1:0]    down_src,
  input  logic                        down_ready
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [SRC_W-1:0] c_last_src = SRC_W'(N_REQ - 1);
  localparam logic [SRC_W:0]   c_n_wide   = (SRC_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  logic [SRC_W-1:0]  owner_q,      owner_d;
  logic [CNT_W-1:0]  burst_q,      burst_d;
  logic              down_valid_q, down_valid_d;
  logic [DATA_W-1:0] down_data_q,  down_data_d;
  logic [SRC_W-1:0]  down_src_q,   down_src_d;

  logic [DATA_W-1:0] w_beat [N_REQ];
  logic              w_hold;
  logic              w_sel_valid;
  logic [SRC_W-1:0]  w_sel;
  logic [SRC_W:0]    w_scan;
  logic              w_can_load;
  logic              w_accept;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_beat[gi] = up_data[gi*DATA_W +: DATA_W];
  end

  // burst_q == 0 only after reset: no lock yet, so arbitration starts at owner+1.
  always_comb begin
    w_hold      = up_valid[owner_q] && (burst_q != '0) && (burst_q < c_max_cnt);
    w_sel       = owner_q;
    w_sel_valid = 1'b0;
    w_scan      = '0;
    if (w_hold) begin
      w_sel_valid = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        w_scan = {1'b0, owner_q} + (SRC_W + 1)'(k);
        if (w_scan >= c_n_wide) begin
          w_scan = w_scan - c_n_wide;
        end
        if (!w_sel_valid && up_valid[w_scan[SRC_W-1:0]]) begin
          w_sel       = w_scan[SRC_W-1:0];
          w_sel_valid = 1'b1;
        end
      end
    end
  end

  assign w_can_load = !down_valid_q || down_ready;
  assign w_accept   = w_sel_valid && w_can_load;

  always_comb begin
    up_ready = '0;
    if (w_accept && rst_n) begin
      up_ready[w_sel] = 1'b1;
    end
  end

  // A rotation grant (even back to the same owner) opens a fresh burst.
  always_comb begin
    owner_d      = owner_q;
    burst_d      = burst_q;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_src_d   = down_src_q;
    if (w_accept) begin
      down_valid_d = 1'b1;
      down_data_d  = w_beat[w_sel];
      down_src_d   = w_sel;
      if (w_hold) begin
        burst_d = burst_q + c_one;
      end else begin
        owner_d = w_sel;
        burst_d = c_one;
      end
    end else if (down_valid_q && down_ready) begin
      down_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= c_last_src;
      burst_q      <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_src_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_src_q   <= down_src_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_src   = down_src_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_stream_arbiter
// Scoreboard bench: reference arbiter predicts grants, queued beats are
// compared as they leave the output register.
// Rev    : 1.0
// ============================================================================
module tb_rr_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 28;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  up_valid;
  logic [N*DW-1:0] up_data;
  logic          down_ready;

  logic [N-1:0]  ur_a, ur_b, ob_ur;
  logic          dv_a, dv_b, ob_dv;
  logic [DW-1:0] dd_a, dd_b, ob_dd;
  logic [SW-1:0] ds_a, ds_b, ob_ds;
  bit            use_b = 1'b0;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_data(up_data), .up_ready(ur_a),
    .down_valid(dv_a), .down_data(dd_a), .down_src(ds_a), .down_ready(down_ready)
  );

  rr_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_data(up_data), .up_ready(ur_b),
    .down_valid(dv_b), .down_data(dd_b), .down_src(ds_b), .down_ready(down_ready)
  );

  assign ob_ur = use_b ? ur_b : ur_a;
  assign ob_dv = use_b ? dv_b : dv_a;
  assign ob_dd = use_b ? dd_b : dd_a;
  assign ob_ds = use_b ? ds_b : ds_a;

  int n_checks = 0;
  int n_errors = 0;
  int budget[N];
  int seq[N];
  int m_owner;
  int m_burst;
  bit m_dv;
  int exp_src[$];
  int exp_data[$];
  int out_log[$];
  bit dr_toggle = 1'b0;
  bit stalled_prev;
  logic [DW-1:0] held_data;
  logic [SW-1:0] held_src;
  int idle_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int max_burst();
    return use_b ? 1 : 4;
  endfunction

  function automatic bit any_budget();
    for (int i = 0; i < N; i++) if (budget[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference arbiter: -1 means nobody is requesting.
  function automatic int pick(input logic [N-1:0] v);
    if (m_burst > 0 && m_burst < max_burst() && v[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_owner + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      up_valid[i] = (budget[i] > 0);
      up_data[i*DW +: DW] = DW'(i * 100 + seq[i]);
    end
  endtask

  task automatic model_reset();
    m_owner = N - 1;
    m_burst = 0;
    m_dv = 1'b0;
    exp_src.delete();
    exp_data.delete();
    stalled_prev = 1'b0;
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  task automatic tick();
    int s;
    bit acc;
    logic [N-1:0] er;
    @(negedge clk);
    s = pick(up_valid);
    acc = (s >= 0) && (!m_dv || down_ready);
    er = '0;
    if (acc) er[s] = 1'b1;
    check("up_ready", 64'(ob_ur), 64'(er));
    check("onehot0", 64'($onehot0(ob_ur)), 64'd1);
    check("down_valid", 64'(ob_dv), 64'(m_dv));
    if (stalled_prev) begin
      check("stall_data", 64'(ob_dd), 64'(held_data));
      check("stall_src", 64'(ob_ds), 64'(held_src));
    end
    if (m_dv && down_ready && exp_src.size() > 0) begin
      int es, ed;
      es = exp_src.pop_front();
      ed = exp_data.pop_front();
      check("out_src", 64'(ob_ds), 64'(es));
      check("out_data", 64'(ob_dd), 64'(ed));
      out_log.push_back(int'(ob_ds));
    end
    stalled_prev = m_dv && !down_ready;
    held_data = ob_dd;
    held_src = ob_ds;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_src.push_back(s);
      exp_data.push_back(s * 100 + seq[s]);
      if (m_burst > 0 && m_burst < max_burst() && s == m_owner) m_burst++;
      else begin
        m_owner = s;
        m_burst = 1;
      end
      m_dv = 1'b1;
      seq[s]++;
      budget[s]--;
      idle_cnt = 0;
    end else begin
      if (m_dv && down_ready) m_dv = 1'b0;
      if (|up_valid) idle_cnt++;
    end
    if (dr_toggle) down_ready = ~down_ready;
    drive();
    if (idle_cnt > 255) begin
      check("watchdog", 64'(idle_cnt), 64'd0);
      finish_run();
    end
  endtask

  task automatic run_phase(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((any_budget() || m_dv) && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 64'(any_budget() || m_dv), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int p1[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int p3[15] = '{1, 1, 3, 3, 3, 3, 1, 1, 1, 3, 3, 3, 3, 3, 3};
    int p6[6]  = '{1, 1, 1, 2, 2, 2};

    rst_n = 1'b1;
    down_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      budget[i] = 1000;
      seq[i] = 0;
    end
    drive();
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check("rst_down_valid", 64'(dv_a), 64'd0);
    check("rst_down_data", 64'(dd_a), 64'd0);
    check("rst_down_src", 64'(ds_a), 64'd0);
    check("rst_up_ready", 64'(ur_a), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All sources busy: bursts of four, rotating 0..3 then back to 0.
    out_log.delete();
    repeat (17) tick();
    for (int i = 0; i < N; i++) budget[i] = 0;
    drive();
    run_phase("p1_done", 20);
    check("p1_count", 64'(out_log.size()), 64'd17);
    for (int i = 0; i < 17 && i < out_log.size(); i++) check("p1_order", 64'(out_log[i]), 64'(p1[i]));

    // Lone source 2 streams ten beats with no bubble at the burst limit.
    out_log.delete();
    budget[2] = 10;
    drive();
    run_phase("p2_done", 40);
    check("p2_count", 64'(out_log.size()), 64'd10);
    foreach (out_log[i]) check("p2_src", 64'(out_log[i]), 64'd2);

    // Source 1 drops after two beats, returns while source 3 holds the lock.
    pulse_reset();
    out_log.delete();
    budget[1] = 2;
    budget[3] = 10;
    drive();
    repeat (3) tick();
    budget[1] = 3;
    drive();
    run_phase("p3_done", 60);
    check("p3_count", 64'(out_log.size()), 64'd15);
    for (int i = 0; i < 15 && i < out_log.size(); i++) check("p3_order", 64'(out_log[i]), 64'(p3[i]));

    // Downstream back-pressure every other cycle.
    out_log.delete();
    for (int i = 0; i < N; i++) budget[i] = 6;
    dr_toggle = 1'b1;
    drive();
    run_phase("p4_done", 200);
    dr_toggle = 1'b0;
    down_ready = 1'b1;
    check("p4_count", 64'(out_log.size()), 64'd24);

    // Asynchronous reset while a beat sits stalled in the output register.
    for (int i = 0; i < N; i++) budget[i] = 1000;
    down_ready = 1'b0;
    drive();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_down_valid", 64'(dv_a), 64'd0);
    check("arst_down_data", 64'(dd_a), 64'd0);
    check("arst_down_src", 64'(ds_a), 64'd0);
    check("arst_up_ready", 64'(ur_a), 64'd0);
    model_reset();
    budget[0] = 0;
    budget[1] = 3;
    budget[2] = 3;
    budget[3] = 0;
    down_ready = 1'b1;
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_log.delete();
    run_phase("p6_done", 40);
    check("p6_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++) check("p6_order", 64'(out_log[i]), 64'(p6[i]));

    // MAX_BURST=1 instance: strict alternation between sources 0 and 3.
    use_b = 1'b1;
    for (int i = 0; i < N; i++) budget[i] = 0;
    budget[0] = 5;
    budget[3] = 5;
    drive();
    pulse_reset();
    out_log.delete();
    run_phase("p5_done", 40);
    check("p5_count", 64'(out_log.size()), 64'd10);
    foreach (out_log[i]) check("p5_order", 64'(out_log[i]), 64'((i % 2 == 0) ? 0 : 3));

    finish_run();
  end

endmodule
`default_nettype wire
